// File: rtl/axil_slave_regfile_pkg.sv
// Shared types and helpers for the AXI4-Lite slave register file.
// Holds response codes, the write/read FSM state encodings and the byte-strobe merge.
// Has no ports. strb_merge works at the widest supported data width (64 bits).
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_VALID
  } rstate_e;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

  // Byte k of the result comes from wdata when wstrb[k] is set, otherwise from old.
  function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
    input logic [MAX_DATA_WIDTH-1:0] old,
    input logic [MAX_DATA_WIDTH-1:0] wdata,
    input logic [MAX_STRB_WIDTH-1:0] wstrb
  );
    logic [MAX_DATA_WIDTH-1:0] r;
    r = old;
    for (int k = 0; k < MAX_STRB_WIDTH; k++) begin
      if (wstrb[k]) r[k*8 +: 8] = wdata[k*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bus bundle: AW/W/B write channels and AR/R read channels.
// master modport drives addresses, data, strobes, valids and response readies;
// slave modport drives address/data readies, responses, read data and response valids.
interface axil_slave_regfile_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register file, NUM_REGS x DATA_WIDTH, byte strobes, SLVERR when unmapped.
// Latency: write commit -> BVALID next cycle; AR handshake -> RVALID next cycle.
// Backpressure: B and R held stable until BREADY / RREADY; AW/W/AR stall meanwhile.
// Ports: ACLK, ARESET (async, active-high), s_axil (slave modport),
//        reg_out (flat register image), wr_pulse (1-cycle per-register write strobe).
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  axil_slave_regfile_if.slave            s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = ADDR_WIDTH - 2;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // ---------------- write path ----------------
  wstate_e               w_state, w_state_nxt;
  logic                  aw_held, w_held;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  resp_e                 bresp_q;
  logic                  awready, wready, bvalid;
  logic                  aw_hs, w_hs, commit;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  wr_mapped;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = ~aw_held;
        wready  = ~w_held;
        if (commit) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (s_axil.BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_hs  = s_axil.AWVALID & awready;
  assign w_hs   = s_axil.WVALID & wready;
  // Commit once each channel is either already held or handshaking this edge.
  assign commit = (w_state == W_IDLE) & (aw_held | aw_hs) & (w_held | w_hs);

  // Held payload takes priority; otherwise use what is on the bus this cycle.
  assign wr_idx  = aw_held ? aw_idx_q : s_axil.AWADDR[ADDR_WIDTH-1:2];
  assign wr_data = w_held  ? w_data_q : s_axil.WDATA;
  assign wr_strb = w_held  ? w_strb_q : s_axil.WSTRB;

  always_comb begin
    wr_mapped = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == IDX_W'(i)) wr_mapped = 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bresp_q  <= RESP_OKAY;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= s_axil.AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= s_axil.WDATA;
        w_strb_q <= s_axil.WSTRB;
      end
    end
  end

  // Unmapped indices match no register, so they leave the array untouched.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && wr_idx == IDX_W'(i)) begin
          regs[i]     <= DATA_WIDTH'(strb_merge(MAX_DATA_WIDTH'(regs[i]),
                                                MAX_DATA_WIDTH'(wr_data),
                                                MAX_STRB_WIDTH'(wr_strb)));
          wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

  // ---------------- read path ----------------
  rstate_e               r_state, r_state_nxt;
  logic                  arready, rvalid, ar_hs;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic                  rd_mapped;
  logic [DATA_WIDTH-1:0] rdata_q;
  resp_e                 rresp_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = 1'b1;
        if (s_axil.ARVALID) r_state_nxt = R_VALID;
      end
      R_VALID: begin
        rvalid = 1'b1;
        if (s_axil.RREADY) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ar_hs  = s_axil.ARVALID & arready;
  assign rd_idx = s_axil.ARADDR[ADDR_WIDTH-1:2];

  always_comb begin
    rd_sel    = '0;
    rd_mapped = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_sel    = regs[i];
        rd_mapped = 1'b1;
      end
    end
  end

  // Sampling regs here on the same edge as a write commit returns the old value.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_sel;
      rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ---------------- outputs ----------------
  assign s_axil.AWREADY = awready;
  assign s_axil.WREADY  = wready;
  assign s_axil.BVALID  = bvalid;
  assign s_axil.BRESP   = bresp_q;
  assign s_axil.ARREADY = arready;
  assign s_axil.RVALID  = rvalid;
  assign s_axil.RDATA   = rdata_q;
  assign s_axil.RRESP   = rresp_q;

  always_comb begin
    reg_out = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  // Byte-offset address bits carry no meaning for word registers.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axil.AWADDR[1:0], s_axil.ARADDR[1:0]};

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for axil_slave_regfile: expected B/R responses are queued at issue time
// and checked by a monitor on each handshake; register image, pulses and ready/valid
// levels are checked inline against hand-computed values.
module tb_axil_slave_regfile;
  import axil_pkg::*;

  logic         aclk = 1'b0;
  logic         areset;
  logic [255:0] reg_out;
  logic [7:0]   wr_pulse;

  always #5 aclk = ~aclk;

  axil_slave_regfile_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  axil_slave_regfile #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
    .ACLK    (aclk),
    .ARESET  (areset),
    .s_axil  (bus),
    .reg_out (reg_out),
    .wr_pulse(wr_pulse)
  );

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [1:0]  b_q [$];
  rexp_t       r_q [$];
  logic [31:0] exp_regs [8];

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [255:0] model_image();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = exp_regs[i];
    return r;
  endfunction

  // Response monitor: sampled mid-cycle, a handshake completes at the next rising edge.
  always @(negedge aclk) begin
    rexp_t e;
    if (!areset) begin
      if (bus.BVALID && bus.BREADY) begin
        if (b_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL b_unexpected: got BRESP %0h, expected no response", bus.BRESP);
        end else begin
          check("bresp", 256'(bus.BRESP), 256'(b_q.pop_front()));
        end
      end
      if (bus.RVALID && bus.RREADY) begin
        if (r_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL r_unexpected: got RDATA %0h, expected no response", bus.RDATA);
        end else begin
          e = r_q.pop_front();
          check("rresp", 256'(bus.RRESP), 256'(e.resp));
          check("rdata", 256'(bus.RDATA), 256'(e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [5:0] a);
    bit ok = 0;
    bus.AWADDR  = a;
    bus.AWVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (bus.AWREADY) begin ok = 1; break; end
    end
    @(posedge aclk);
    #1;
    bus.AWVALID = 1'b0;
    if (!ok) begin vectors++; miscompares++; $display("FAIL aw_timeout: got no AWREADY, expected 1"); end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    bus.WDATA  = d;
    bus.WSTRB  = s;
    bus.WVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (bus.WREADY) begin ok = 1; break; end
    end
    @(posedge aclk);
    #1;
    bus.WVALID = 1'b0;
    if (!ok) begin vectors++; miscompares++; $display("FAIL w_timeout: got no WREADY, expected 1"); end
  endtask

  task automatic send_ar(input logic [5:0] a);
    bit ok = 0;
    bus.ARADDR  = a;
    bus.ARVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (bus.ARREADY) begin ok = 1; break; end
    end
    @(posedge aclk);
    #1;
    bus.ARVALID = 1'b0;
    if (!ok) begin vectors++; miscompares++; $display("FAIL ar_timeout: got no ARREADY, expected 1"); end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp);
    b_q.push_back(resp);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  initial begin
    areset      = 1'b1;
    bus.AWADDR  = '0; bus.AWVALID = 1'b0;
    bus.WDATA   = '0; bus.WSTRB   = '0; bus.WVALID = 1'b0;
    bus.ARADDR  = '0; bus.ARVALID = 1'b0;
    bus.BREADY  = 1'b1;
    bus.RREADY  = 1'b1;
    for (int i = 0; i < 8; i++) exp_regs[i] = '0;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", 256'(bus.AWREADY), 256'(1));
    check("rst_wready",  256'(bus.WREADY),  256'(1));
    check("rst_arready", 256'(bus.ARREADY), 256'(1));
    check("rst_valids",  256'({bus.BVALID, bus.RVALID}), 256'(0));
    check("rst_resps",   256'({bus.BRESP, bus.RRESP}),   256'(0));
    check("rst_rdata",   256'(bus.RDATA), 256'(0));
    check("rst_wr_pulse", 256'(wr_pulse), 256'(0));
    check("rst_reg_out", reg_out, 256'(0));
    areset = 1'b0;
    tick();

    // 1: AW and W in the same cycle
    do_write(6'h04, 32'hDEADBEEF, 4'hF, RESP_OKAY);
    exp_regs[1] = 32'hDEADBEEF;
    check("t1_bvalid",   256'(bus.BVALID), 256'(1));
    check("t1_wr_pulse", 256'(wr_pulse), 256'(8'b0000_0010));
    check("t1_reg_out",  reg_out, model_image());
    tick();
    check("t1_pulse_clr", 256'(wr_pulse), 256'(0));
    check("t1_bvalid_clr", 256'(bus.BVALID), 256'(0));

    // 2: W three cycles ahead of AW, partial strobe
    do_write(6'h08, 32'hAABBCCDD, 4'hF, RESP_OKAY);
    exp_regs[2] = 32'hAABBCCDD;
    tick();
    b_q.push_back(RESP_OKAY);
    send_w(32'h11223344, 4'h5);
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_wait", 256'(bus.WREADY), 256'(0));
      check("t2_no_bvalid",   256'(bus.BVALID), 256'(0));
      tick();
    end
    send_aw(6'h08);
    exp_regs[2] = 32'hAA22CC44;
    check("t2_bvalid",   256'(bus.BVALID), 256'(1));
    check("t2_reg_out",  reg_out, model_image());
    check("t2_wr_pulse", 256'(wr_pulse), 256'(8'b0000_0100));

    // 3: read with R backpressure
    bus.RREADY = 1'b0;
    r_q.push_back('{resp: RESP_OKAY, data: 32'hDEADBEEF});
    send_ar(6'h04);
    for (int i = 0; i < 4; i++) begin
      check("t3_rvalid_held", 256'(bus.RVALID),  256'(1));
      check("t3_arready_lo",  256'(bus.ARREADY), 256'(0));
      check("t3_rdata_held",  256'(bus.RDATA),   256'(32'hDEADBEEF));
      tick();
    end
    bus.RREADY = 1'b1;
    tick();
    check("t3_rvalid_clr", 256'(bus.RVALID),  256'(0));
    check("t3_arready_hi", 256'(bus.ARREADY), 256'(1));

    // 4: unmapped write and read
    do_write(6'h3C, 32'h5, 4'hF, RESP_SLVERR);
    check("t4_no_pulse",  256'(wr_pulse), 256'(0));
    check("t4_reg_out",   reg_out, model_image());
    tick();
    r_q.push_back('{resp: RESP_SLVERR, data: 32'h0});
    send_ar(6'h20);
    check("t4_rvalid", 256'(bus.RVALID), 256'(1));
    tick();

    // 5: same-edge read and write to reg3
    do_write(6'h0C, 32'h7, 4'hF, RESP_OKAY);
    exp_regs[3] = 32'h7;
    tick();
    b_q.push_back(RESP_OKAY);
    r_q.push_back('{resp: RESP_OKAY, data: 32'h7});
    fork
      send_aw(6'h0C);
      send_w(32'h1, 4'hF);
      send_ar(6'h0C);
    join
    exp_regs[3] = 32'h1;
    check("t5_reg_out", reg_out, model_image());
    tick();
    r_q.push_back('{resp: RESP_OKAY, data: 32'h1});
    send_ar(6'h0C);
    tick();

    // 6: reset while both responses are pending
    bus.BREADY = 1'b0;
    bus.RREADY = 1'b0;
    fork
      send_aw(6'h00);
      send_w(32'h55, 4'hF);
      send_ar(6'h04);
    join
    check("t6_bvalid_pending", 256'(bus.BVALID), 256'(1));
    check("t6_rvalid_pending", 256'(bus.RVALID), 256'(1));
    tick();
    #2;
    areset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) exp_regs[i] = '0;
    check("t6_bvalid_drop", 256'(bus.BVALID), 256'(0));
    check("t6_rvalid_drop", 256'(bus.RVALID), 256'(0));
    check("t6_reg_out_clr", reg_out, model_image());
    check("t6_readies", 256'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 256'(3'b111));
    @(posedge aclk);
    #1;
    areset = 1'b0;
    bus.BREADY = 1'b1;
    bus.RREADY = 1'b1;
    tick();
    do_write(6'h10, 32'h12345678, 4'hF, RESP_OKAY);
    exp_regs[4] = 32'h12345678;
    check("t6_post_reg_out",  reg_out, model_image());
    check("t6_post_wr_pulse", 256'(wr_pulse), 256'(8'b0001_0000));
    tick();
    tick();

    check("b_queue_drained", 256'(b_q.size()), 256'(0));
    check("r_queue_drained", 256'(r_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
